// File: rtl/muxn_stream.sv
// muxn_stream: N-channel packet multiplexer with a registered output stage.
// A grant is locked to one input channel from its first beat until the beat
// marked last, so packets from different channels never interleave.
// Channel selection uses the external sel port (mode 0). If MUXN_STREAM_RR_EN
// is defined, mode 1 selects channels by round-robin arbitration instead.
// If MUXN_STREAM_RR_EN is not defined, the mode port is ignored and the
// round-robin pointer is not built.

module muxn_stream #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SELW  = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SELW-1:0]    out_chan,
    input  logic               out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_nx;
    logic [SELW-1:0]   g, g_nx;
    logic              can_load;
    logic              take;
    logic              sel_ok;
    logic [WIDTH-1:0]  g_data;

    // The output register can accept a new beat when it is empty or is being drained in this cycle
    assign can_load = !out_valid || out_ready;
    assign take     = (state == LOCKED) && in_valid[g] && can_load;
    assign sel_ok   = (int'(sel) < N);

`ifdef MUXN_STREAM_RR_EN
    logic [SELW-1:0]   ptr, ptr_nx;
    logic [SELW-1:0]   rr_idx;
    logic [SELW-1:0]   rr_pick;
    logic              rr_found;

    // Find the first valid channel after the last granted channel, wrapping at N
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            rr_idx = SELW'((int'(ptr) + i) % N);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Route the data of the granted channel to the output register
    always_comb begin
        g_data = '0;
        for (int k = 0; k < N; k++) begin
            if (SELW'(k) == g) g_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Assert ready only on the granted channel, and only if the output stage can take a beat
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = (state == LOCKED) && (SELW'(k) == g) && can_load;
        end
    end

    // Next-state logic: grant a channel in IDLE, and release the grant after the last beat transfers
    always_comb begin
        state_nx = state;
        g_nx     = g;
`ifdef MUXN_STREAM_RR_EN
        ptr_nx   = ptr;
`endif
        case (state)
            IDLE: begin
`ifdef MUXN_STREAM_RR_EN
                if (mode) begin
                    if (rr_found) begin
                        state_nx = LOCKED;
                        g_nx     = rr_pick;
                        ptr_nx   = rr_pick;
                    end
                end else if (sel_ok && in_valid[sel]) begin
                    state_nx = LOCKED;
                    g_nx     = sel;
                end
`else
                if (sel_ok && in_valid[sel]) begin
                    state_nx = LOCKED;
                    g_nx     = sel;
                end
`endif
            end
            LOCKED: begin
                if (take && in_last[g]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registers for the FSM state, the grant, and the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
`ifdef MUXN_STREAM_RR_EN
            ptr   <= SELW'(N - 1);
`endif
        end else begin
            state <= state_nx;
            g     <= g_nx;
`ifdef MUXN_STREAM_RR_EN
            ptr   <= ptr_nx;
`endif
        end
    end

    // Output stage: load a beat on transfer, clear valid when drained, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_last  <= in_last[g];
            out_chan  <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_stream.sv
// tb_muxn_stream: directed self-checking bench for muxn_stream.
// A second instance with N=5 covers sel values that are encodable but are not valid channels.

module tb_muxn_stream;

    localparam int WIDTH  = 16;
    localparam int N      = 4;
    localparam int SELW   = 2;
    localparam int BWIDTH = 8;
    localparam int BN     = 5;
    localparam int BSELW  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic [SELW-1:0]    out_chan;
    logic               out_ready;

    logic [BN*BWIDTH-1:0] b_in_data;
    logic [BN-1:0]        b_in_valid;
    logic [BN-1:0]        b_in_last;
    logic [BN-1:0]        b_in_ready;
    logic [BSELW-1:0]     b_sel;
    logic                 b_mode;
    logic [BWIDTH-1:0]    b_out_data;
    logic                 b_out_valid;
    logic                 b_out_last;
    logic [BSELW-1:0]     b_out_chan;
    logic                 b_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muxn_stream #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .sel(sel), .mode(mode),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_chan(out_chan), .out_ready(out_ready)
    );

    muxn_stream #(.WIDTH(BWIDTH), .N(BN)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_last(b_in_last), .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_chan(b_out_chan), .out_ready(b_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all_channels();
        for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 16'hC000 + 16'(k);
        in_valid = 4'b1111;
        in_last  = 4'b1111;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        in_last  = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_data = '0; in_valid = '0; in_last = '0; sel = '0; mode = 1'b0; out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_in_last = '0; b_sel = 3'd5; b_mode = 1'b0; b_out_ready = 1'b1;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid got %0b want 0", out_valid); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_out_data got %h want 0000", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_last got %0b want 0", out_last); end
        n_checks++; if (out_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_out_chan got %0d want 0", out_chan); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_in_ready got %b want 0000", in_ready); end
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_b_out_valid got %0b want 0", b_out_valid); end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_packet();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_valid = 4'b0100; in_last = 4'b0000;
        in_data[2*WIDTH +: WIDTH] = 16'h1111;
        step();
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL m0_grant in_ready got %b want 0100", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1111) begin n_fail++; $display("[TB] FAIL m0_beat1 got v=%0b d=%h want v=1 d=1111", out_valid, out_data); end
        n_checks++; if (out_chan !== 2'd2 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL m0_beat1_tag got ch=%0d l=%0b want ch=2 l=0", out_chan, out_last); end
        in_data[2*WIDTH +: WIDTH] = 16'h2222;
        step();
        n_checks++; if (out_data !== 16'h2222 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL m0_beat2 got d=%h l=%0b want d=2222 l=0", out_data, out_last); end
        in_data[2*WIDTH +: WIDTH] = 16'h3333; in_last = 4'b0100;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_last !== 1'b1 || out_chan !== 2'd2) begin n_fail++; $display("[TB] FAIL m0_beat3 got v=%0b d=%h l=%0b ch=%0d want v=1 d=3333 l=1 ch=2", out_valid, out_data, out_last, out_chan); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL m0_idle in_ready got %b want 0000", in_ready); end
        in_valid = 4'b0000; in_last = 4'b0000;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL m0_drain out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_sel_change();
        mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
        in_data[1*WIDTH +: WIDTH] = 16'h00A1;
        in_data[3*WIDTH +: WIDTH] = 16'h00B1;
        in_valid = 4'b1010; in_last = 4'b1000;
        step();
        sel = 2'd3;
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL selchg_grant1 got %b want 0010", in_ready); end
        step();
        n_checks++; if (out_data !== 16'h00A1 || out_chan !== 2'd1 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL selchg_a1 got d=%h ch=%0d l=%0b want d=00a1 ch=1 l=0", out_data, out_chan, out_last); end
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL selchg_hold in_ready got %b want 0010", in_ready); end
        in_data[1*WIDTH +: WIDTH] = 16'h00A2; in_last = 4'b1010;
        step();
        n_checks++; if (out_data !== 16'h00A2 || out_chan !== 2'd1 || out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL selchg_a2 got d=%h ch=%0d l=%0b want d=00a2 ch=1 l=1", out_data, out_chan, out_last); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL selchg_idle got %b want 0000", in_ready); end
        in_valid = 4'b1000;
        step();
        n_checks++; if (in_ready !== 4'b1000 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL selchg_grant3 got rdy=%b v=%0b want rdy=1000 v=0", in_ready, out_valid); end
        step();
        n_checks++; if (out_data !== 16'h00B1 || out_chan !== 2'd3 || out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL selchg_b1 got d=%h ch=%0d l=%0b want d=00b1 ch=3 l=1", out_data, out_chan, out_last); end
        in_valid = 4'b0000; in_last = 4'b0000;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL selchg_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] q[$];
        int bi     = 0;
        int n_recv = 0;
        logic sent, recv;
        mode = 1'b0; sel = 2'd0;
        in_valid = 4'b0001; in_last = 4'b0000;
        in_data[0 +: WIDTH] = 16'hA000;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            #1;
            sent = in_valid[0] && in_ready[0];
            recv = out_valid && out_ready;
            if (c >= 4 && c <= 8) begin
                n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_stall_ready c=%0d got %b want 0000", c, in_ready); end
            end
            if (c >= 2 && c <= 14) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_bubble c=%0d out_valid got %0b want 1", c, out_valid); end
            end
            if (c >= 9 && c <= 13) begin
                n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL bp_fullrate c=%0d in_ready got %b want 0001", c, in_ready); end
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL bp_extra c=%0d got d=%h want no beat", c, out_data);
                end else if (out_data !== q[0] || out_chan !== 2'd0 || out_last !== (q[0] == 16'hA007)) begin
                    n_fail++; $display("[TB] FAIL bp_beat c=%0d got d=%h ch=%0d l=%0b want d=%h ch=0 l=%0b", c, out_data, out_chan, out_last, q[0], (q[0] == 16'hA007));
                end
            end
            if (recv && q.size() > 0) begin
                void'(q.pop_front());
                n_recv++;
            end
            @(posedge clk);
            if (sent) begin
                q.push_back(16'hA000 + 16'(bi));
                bi++;
            end
            #1;
            if (sent) begin
                if (bi < 8) begin
                    in_data[0 +: WIDTH] = 16'hA000 + 16'(bi);
                    in_last = (bi == 7) ? 4'b0001 : 4'b0000;
                end else begin
                    in_valid = 4'b0000; in_last = 4'b0000;
                end
            end
            if (n_recv == 8 && c > 15) break;
        end
        n_checks++; if (n_recv != 8 || q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_count got recv=%0d pending=%0d want recv=8 pending=0", n_recv, q.size()); end
        out_ready = 1'b1;
    endtask

    task automatic test_sel_out_of_range();
        b_mode = 1'b0; b_sel = 3'd5; b_out_ready = 1'b1;
        b_in_valid = 5'b11111; b_in_last = 5'b11111;
        b_in_data[4*BWIDTH +: BWIDTH] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (b_in_ready !== 5'b00000 || b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sel5_nogrant i=%0d got rdy=%b v=%0b want rdy=00000 v=0", i, b_in_ready, b_out_valid); end
        end
        b_sel = 3'd4;
        step();
        n_checks++; if (b_in_ready !== 5'b10000) begin n_fail++; $display("[TB] FAIL sel4_grant got %b want 10000", b_in_ready); end
        step();
        n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h5A || b_out_chan !== 3'd4 || b_out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL sel4_beat got v=%0b d=%h ch=%0d l=%0b want v=1 d=5a ch=4 l=1", b_out_valid, b_out_data, b_out_chan, b_out_last); end
        b_in_valid = 5'b00000;
    endtask

`ifdef MUXN_STREAM_RR_EN
    task automatic test_round_robin();
        int e;
        do_reset();
        mode = 1'b1; sel = 2'd2; out_ready = 1'b1;
        fill_all_channels();
        for (int i = 0; i < 5; i++) begin
            e = i % 4;
            step();
            n_checks++; if (in_ready !== 4'(1 << e)) begin n_fail++; $display("[TB] FAIL rr_grant%0d got %b want %b", i, in_ready, 4'(1 << e)); end
            step();
            n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'(e) || out_data !== 16'hC000 + 16'(e) || out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_beat%0d got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h", i, out_valid, out_chan, out_data, e, 16'hC000 + 16'(e)); end
        end
        in_valid = 4'b1000;
        step();
        n_checks++; if (in_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL rr_only3 got %b want 1000", in_ready); end
        step();
        n_checks++; if (out_chan !== 2'd3 || out_data !== 16'hC003) begin n_fail++; $display("[TB] FAIL rr_only3_beat got ch=%0d d=%h want ch=3 d=c003", out_chan, out_data); end
        in_valid = 4'b0000; in_last = 4'b0000;
        step();
    endtask
`else
    task automatic test_mode_ignored();
        do_reset();
        mode = 1'b1; sel = 2'd2; out_ready = 1'b1;
        fill_all_channels();
        step();
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL modeign_grant got %b want 0100", in_ready); end
        step();
        n_checks++; if (out_chan !== 2'd2 || out_data !== 16'hC002) begin n_fail++; $display("[TB] FAIL modeign_beat got ch=%0d d=%h want ch=2 d=c002", out_chan, out_data); end
        in_valid = 4'b0000; in_last = 4'b0000;
        step();
    endtask
`endif

    task automatic test_reset_mid_packet();
        logic [N-1:0]    exp_rdy;
        logic [SELW-1:0] exp_ch;
`ifdef MUXN_STREAM_RR_EN
        exp_rdy = 4'b0001; exp_ch = 2'd0;
`else
        exp_rdy = 4'b0100; exp_ch = 2'd2;
`endif
        mode = 1'b0; sel = 2'd1; out_ready = 1'b0;
        in_valid = 4'b0010; in_last = 4'b0000;
        in_data[1*WIDTH +: WIDTH] = 16'h7777;
        step();
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h7777) begin n_fail++; $display("[TB] FAIL midrst_pre got v=%0b d=%h want v=1 d=7777", out_valid, out_data); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_clear got v=%0b d=%h l=%0b ch=%0d rdy=%b want all zero", out_valid, out_data, out_last, out_chan, in_ready); end
        step();
        rst_n = 1'b1;
        mode = 1'b1; sel = 2'd2; out_ready = 1'b1;
        fill_all_channels();
        step();
        n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("[TB] FAIL midrst_grant got %b want %b", in_ready, exp_rdy); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_chan !== exp_ch || out_data !== 16'hC000 + 16'(exp_ch)) begin n_fail++; $display("[TB] FAIL midrst_beat got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h", out_valid, out_chan, out_data, exp_ch, 16'hC000 + 16'(exp_ch)); end
        in_valid = 4'b0000; in_last = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_mode0_packet();
        test_sel_change();
        test_backpressure();
        test_sel_out_of_range();
`ifdef MUXN_STREAM_RR_EN
        test_round_robin();
`else
        test_mode_ignored();
`endif
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
